// File: rtl/pa2_seq_issuer_if.sv
// Producer-side, pa2_fsm-side and status signals of the sequence issuer.
// The slave modport is the issuer's view; the master modport is its environment's view.
interface pa2_seq_issuer_if;
    logic       in_valid;
    logic [3:0] in_seq;
    logic       in_last;
    logic       in_ready;
    logic       hit;
    logic       valid;
    logic [3:0] seq;
    logic       busy;
    logic       seq_done;
    logic [3:0] hit_count;
    logic       err_trunc;
    logic       err_hit;

    modport slave (
        input  in_valid, in_seq, in_last, hit,
        output in_ready, valid, seq, busy, seq_done, hit_count, err_trunc, err_hit
    );

    modport master (
        output in_valid, in_seq, in_last, hit,
        input  in_ready, valid, seq, busy, seq_done, hit_count, err_trunc, err_hit
    );
endinterface

// File: rtl/pa2_seq_issuer.sv
// Buffers {last,seq} words and replays each complete sequence to pa2_fsm as one burst,
// then counts the following hit train before allowing the next issue.
module pa2_seq_issuer #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 10,
    parameter int GAP     = 1
) (
    input  logic clk,
    input  logic rst,
    pa2_seq_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_GAP} state_t;

    logic [4:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count, last_cnt;
    logic [4:0]    head;
    logic          full, push, pop, start;

    state_t        state;
    logic          valid_r, seq_done_r, err_trunc_r, err_hit_r, ending;
    logic [3:0]    seq_r, hit_count_r, len, hits;
    logic [GW-1:0] gap_cnt;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = bus.in_valid && !full;
    assign start = (last_cnt != '0) || full;
    assign pop   = ((state == S_IDLE) && start) || ((state == S_ISSUE) && !ending);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_last, bus.in_seq};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({push && bus.in_last, pop && head[4]})
                2'b10:   last_cnt <= last_cnt + (AW+1)'(1);
                2'b01:   last_cnt <= last_cnt - (AW+1)'(1);
                default: last_cnt <= last_cnt;
            endcase
        end
    end

    // 'ending' marks that the word currently on seq closes the burst, so the next
    // edge drops valid without popping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            valid_r     <= 1'b0;
            seq_r       <= '0;
            seq_done_r  <= 1'b0;
            hit_count_r <= '0;
            err_trunc_r <= 1'b0;
            err_hit_r   <= 1'b0;
            ending      <= 1'b0;
            len         <= '0;
            hits        <= '0;
            gap_cnt     <= '0;
        end else begin
            seq_done_r <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_ISSUE;
                    valid_r <= 1'b1;
                    seq_r   <= head[3:0];
                    len     <= 4'd1;
                    ending  <= head[4] || (MAX_LEN == 1);
                    if (!head[4] && (MAX_LEN == 1)) err_trunc_r <= 1'b1;
                end
                S_ISSUE: if (ending) begin
                    valid_r <= 1'b0;
                    seq_r   <= '0;
                    hits    <= '0;
                    state   <= S_DRAIN;
                end else begin
                    seq_r  <= head[3:0];
                    len    <= len + 4'd1;
                    ending <= head[4] || (len == 4'(MAX_LEN - 1));
                    if (!head[4] && (len == 4'(MAX_LEN - 1))) err_trunc_r <= 1'b1;
                end
                S_DRAIN: if (bus.hit && (hits != 4'(MAX_LEN))) begin
                    hits <= hits + 4'd1;
                end else begin
                    if (bus.hit) err_hit_r <= 1'b1;
                    seq_done_r  <= 1'b1;
                    hit_count_r <= hits;
                    gap_cnt     <= '0;
                    state       <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) state <= S_IDLE;
                    else                         gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.valid     = valid_r;
    assign bus.seq       = seq_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.seq_done  = seq_done_r;
    assign bus.hit_count = hit_count_r;
    assign bus.err_trunc = err_trunc_r;
    assign bus.err_hit   = err_hit_r;
endmodule

// File: tb/tb_pa2_seq_issuer.sv
// Directed bench for pa2_seq_issuer: stimulus queues expected words, burst lengths and
// hit counts; a monitor pops and compares whenever the DUT presents them.
module tb_pa2_seq_issuer;
    localparam int MAX_LEN = 10;
    localparam int GAP     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pa2_seq_issuer_if bus();

    pa2_seq_issuer #(.DEPTH(16), .MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int hit_plan = 0;
    int cyc = 0;
    logic [3:0] exp_seq[$];
    int exp_len[$];
    int exp_done[$];

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // pa2_fsm stand-in: a train of hit_plan hits starting the first cycle valid is low
    initial begin
        int rem = 0;
        logic pv = 1'b0;
        bus.hit = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                rem = 0; pv = 1'b0; bus.hit = 1'b0;
            end else begin
                if (pv && !bus.valid) rem = hit_plan;
                bus.hit = (rem > 0);
                if (rem > 0) rem--;
                pv = bus.valid;
            end
        end
    end

    initial begin
        int run = 0;
        int last_done = -1000;
        logic pv = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                run = 0; pv = 1'b0; last_done = -1000;
            end else begin
                if (bus.valid) begin
                    if (!pv) check("gap_before_burst", int'(cyc - last_done >= GAP + 1), 1);
                    run++;
                    if (exp_seq.size() == 0) fail_now("unexpected_word");
                    else check("seq_word", int'(bus.seq), int'(exp_seq.pop_front()));
                end else begin
                    check("seq_zero_when_idle", int'(bus.seq), 0);
                    if (pv) begin
                        if (exp_len.size() == 0) fail_now("unexpected_burst");
                        else check("burst_len", run, exp_len.pop_front());
                        run = 0;
                    end
                end
                if (bus.seq_done) begin
                    if (exp_done.size() == 0) fail_now("unexpected_seq_done");
                    else check("hit_count", int'(bus.hit_count), exp_done.pop_front());
                    last_done = cyc;
                end
                pv = bus.valid;
            end
        end
    end

    task automatic push_word(input logic [3:0] s, input logic l);
        int t = 0;
        exp_seq.push_back(s);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_seq = s; bus.in_last = l;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        if (!bus.in_ready) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_done.size() != 0 || exp_len.size() != 0 || bus.busy) && t < 400) begin
            @(posedge clk); t++;
        end
        check("drain_timeout", int'(t < 400), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_seq = '0; bus.in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.valid), 0);
        check("rst_seq", int'(bus.seq), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_seq_done", int'(bus.seq_done), 0);
        check("rst_hit_count", int'(bus.hit_count), 0);
        check("rst_err_trunc", int'(bus.err_trunc), 0);
        check("rst_err_hit", int'(bus.err_hit), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 10-word sequence, no hits; valid must rise the edge after the last word lands
        hit_plan = 0; exp_len.push_back(10); exp_done.push_back(0);
        for (int i = 0; i < 10; i++) push_word(4'(i + 1), i == 9);
        check("latency_before", int'(bus.valid), 0);
        @(posedge clk); #1;
        check("latency_after", int'(bus.valid), 1);
        wait_idle();

        // same sequence, 10 hits
        hit_plan = 10; exp_len.push_back(10); exp_done.push_back(10);
        for (int i = 0; i < 10; i++) push_word(4'(i + 1), i == 9);
        wait_idle();

        // back-to-back one-word sequences with one hit each
        hit_plan = 1;
        for (int i = 0; i < 3; i++) begin exp_len.push_back(1); exp_done.push_back(1); end
        push_word(4'hA, 1'b1);
        push_word(4'h5, 1'b1);
        push_word(4'hF, 1'b1);
        wait_idle();

        // 16 words, no last: fill, truncate at MAX_LEN, leftovers join the next sequence
        hit_plan = 0; exp_len.push_back(10); exp_done.push_back(0);
        for (int i = 0; i < 16; i++) push_word(4'((i * 3 + 2) & 15), 1'b0);
        check("full_in_ready", int'(bus.in_ready), 0);
        wait_idle();
        check("err_trunc_set", int'(bus.err_trunc), 1);
        check("in_ready_back", int'(bus.in_ready), 1);
        exp_len.push_back(7); exp_done.push_back(0);
        push_word(4'h9, 1'b1);
        wait_idle();
        check("err_hit_clear", int'(bus.err_hit), 0);

        // stuck hit: counted up to MAX_LEN, then flagged and abandoned
        hit_plan = 20; exp_len.push_back(2); exp_done.push_back(MAX_LEN);
        push_word(4'hC, 1'b0);
        push_word(4'hD, 1'b1);
        wait_idle();
        check("err_hit_set", int'(bus.err_hit), 1);
        hit_plan = 0; exp_len.push_back(1); exp_done.push_back(0);
        push_word(4'h3, 1'b1);
        wait_idle();

        // reset in the middle of a burst
        exp_len.push_back(8); exp_done.push_back(0);
        for (int i = 0; i < 8; i++) push_word(4'(15 - i), i == 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", int'(bus.valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.valid), 0);
        check("mid_rst_seq", int'(bus.seq), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_err_trunc", int'(bus.err_trunc), 0);
        check("mid_rst_err_hit", int'(bus.err_hit), 0);
        check("mid_rst_hit_count", int'(bus.hit_count), 0);
        exp_seq.delete(); exp_len.delete(); exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_len.push_back(1); exp_done.push_back(0);
        push_word(4'h7, 1'b1);
        wait_idle();
        check("leftover_words", exp_seq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
